disp_vramctrl: RTL and testbench
================================

DISP_VRAMCTRL -- requirements
Module: disp_vramctrl

Interface
REQ-001 Parameter FRAME_BURSTS, default 9600, meaning bursts per frame (640x480x4 bytes / 128 bytes).
REQ-002 Parameter BURST_LEN, default 16, meaning beats per burst (64-bit beats; ARLEN = BURST_LEN-1).
REQ-003 ACLK  input  1  system clock; every register in the block is clocked on its rising edge.
REQ-004 ARST  input  1  reset; asynchronous, active-high.
REQ-005 DISPON  input  1  display enable from the register block.
REQ-006 DISPADDR  input  29  frame base address from the register block, in 8-byte units.
REQ-007 DSP_VSYNC_X  input  1  vertical sync from the display timing block, active-low, asynchronous to ACLK.
REQ-008 FIFO_READY  input  1  pixel FIFO has room for one full burst.
REQ-009 ARADDR  output  32  AXI read address.
REQ-010 ARLEN  output  8  AXI burst length, constant BURST_LEN-1.
REQ-011 ARVALID  output  1  AXI read-address valid.
REQ-012 ARREADY  input  1  AXI read-address ready.
REQ-013 RDATA  input  64  AXI read data.
REQ-014 RVALID  input  1  AXI read-data valid.
REQ-015 RLAST  input  1  AXI last beat of the burst.
REQ-016 RREADY  output  1  AXI read-data ready.
REQ-017 FIFO_WR  output  1  pixel FIFO write strobe.
REQ-018 FIFO_WDATA  output  64  pixel FIFO write data.
REQ-019 FRAME_BUSY  output  1  a frame transfer is in progress.

Function
REQ-020 DSP_VSYNC_X SHALL pass through a 2-flop synchronizer plus one history flop; frame start = synchronized 1->0 transition.
REQ-021 State machine SHALL have the states HALT, WAITVS, WAITBUF, AREQ and RDAT.
REQ-022 HALT: stay in HALT while DISPON=0; go to WAITVS when DISPON=1.
REQ-023 WAITVS: on frame start, latch base = {DISPADDR, 3'b000}, clear the burst counter, set FRAME_BUSY=1, and go to WAITBUF; if DISPON=0, go to HALT.
REQ-024 WAITBUF: go to AREQ when FIFO_READY=1; if DISPON=0 here, go to HALT with FRAME_BUSY cleared.
REQ-025 AREQ: hold ARVALID=1 with ARADDR stable; on ARVALID&ARREADY, drop ARVALID and go to RDAT.
REQ-026 ARADDR SHALL be base + burst_count*BURST_LEN*8, computed modulo 2^32, with wrap permitted.
REQ-027 RDAT: RREADY=1; FIFO_WR = RVALID&RREADY; FIFO_WDATA = RDATA in the same cycle (combinational path).
REQ-028 Burst end = RVALID&RLAST in RDAT; the burst counter increments on that cycle.
REQ-029 Burst end with counter = FRAME_BURSTS-1: clear FRAME_BUSY and go to WAITVS (HALT if DISPON=0).
REQ-030 Other burst ends: go to WAITBUF (HALT if DISPON=0).
REQ-031 DISPON dropping in AREQ or RDAT SHALL NOT abort the transaction: the burst completes, then the FSM goes to HALT.
REQ-032 A frame start while FRAME_BUSY=1 SHALL be ignored; the current frame continues.
REQ-033 DISPADDR changes SHALL take effect only at the next frame start.
REQ-034 RVALID outside RDAT SHALL produce no FIFO_WR.
REQ-035 Frame start and DISPON fall in the same WAITVS cycle: DISPON wins, and the FSM goes to HALT.
REQ-036 Latency: ARVALID SHALL rise 4 ACLK edges after the first edge that samples DSP_VSYNC_X low, given DISPON=1 and FIFO_READY=1.

Reset
REQ-037 While ARST=1, the block SHALL hold: state HALT; ARVALID, RREADY, FIFO_WR, FRAME_BUSY = 0; ARADDR = 0; ARLEN = BURST_LEN-1; burst counter 0; synchronizer flops 1.
REQ-038 ARST asserted mid-burst SHALL force the reset values immediately; no completion of the outstanding burst is attempted.

Verification
REQ-039 The bench SHALL cover basic frame: FRAME_BURSTS=4, DISPADDR=29'h0200_0000, FIFO_READY=1, single vsync -> ARADDR 32'h1000_0000, 32'h1000_0080, 32'h1000_0100, 32'h1000_0180; 64 FIFO_WR pulses; FRAME_BUSY falls after the 4th RLAST.
REQ-040 The bench SHALL cover backpressure: ARREADY held low 10 cycles, RVALID gapped -> ARADDR stable, FIFO_WR only on RVALID cycles, beat count still 16 per burst.
REQ-041 The bench SHALL cover FIFO throttle: FIFO_READY=0 after burst 1 for 50 cycles -> no ARVALID during the hold; burst 2 issued within 2 cycles of FIFO_READY=1.
REQ-042 The bench SHALL cover DISPON drop mid-burst at beat 5 -> remaining 11 beats accepted, then HALT; no further ARVALID; FRAME_BUSY=0.
REQ-043 The bench SHALL cover extra vsync during a frame, and DISPADDR changed mid-frame -> no restart; the new base is used from the next vsync.
REQ-044 The bench SHALL cover reset during RDAT -> all outputs at reset values immediately; after release with DISPON=1, the next vsync starts at burst 0.

Source files
------------

// File: rtl/disp_vramctrl.sv
// Display VRAM read controller: on each vsync, fetch one frame from memory
// as a sequence of fixed-length AXI read bursts and stream it into the pixel FIFO.
module disp_vramctrl #(
  parameter int unsigned FRAME_BURSTS = 9600,
  parameter int unsigned BURST_LEN    = 16
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        DISPON,
  input  logic [28:0] DISPADDR,
  input  logic        DSP_VSYNC_X,
  input  logic        FIFO_READY,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [63:0] RDATA,
  input  logic        RVALID,
  input  logic        RLAST,
  output logic        RREADY,
  output logic        FIFO_WR,
  output logic [63:0] FIFO_WDATA,
  output logic        FRAME_BUSY
);

  localparam int unsigned CNT_W       = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam int unsigned BURST_BYTES = BURST_LEN * 8;
  localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(FRAME_BURSTS - 1);

  typedef enum logic [2:0] {
    HALT    = 3'd0,
    WAITVS  = 3'd1,
    WAITBUF = 3'd2,
    AREQ    = 3'd3,
    RDAT    = 3'd4
  } state_t;

  state_t           state;
  logic             vs_s1;
  logic             vs_s2;
  logic             vs_hist;
  logic             frame_start;
  logic             burst_end;
  logic [CNT_W-1:0] burst_cnt;
  logic [31:0]      burst_addr;

  // Bring the asynchronous vsync into ACLK and keep one sample of history.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      vs_s1   <= 1'b1;
      vs_s2   <= 1'b1;
      vs_hist <= 1'b1;
    end else begin
      vs_s1   <= DSP_VSYNC_X;
      vs_s2   <= vs_s1;
      vs_hist <= vs_s2;
    end
  end

  assign frame_start = vs_hist & ~vs_s2;
  assign burst_end   = (state == RDAT) & RVALID & RLAST;

  // Burst length never changes; read data goes straight into the FIFO.
  assign ARLEN      = 8'(BURST_LEN - 1);
  assign FIFO_WR    = RVALID & RREADY;
  assign FIFO_WDATA = RDATA;

  // Frame fetch sequencer: waits for vsync, then issues one burst per FIFO slot.
  // ARVALID is raised one cycle after entering AREQ, once ARADDR has settled.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state      <= HALT;
      ARVALID    <= 1'b0;
      RREADY     <= 1'b0;
      FRAME_BUSY <= 1'b0;
      ARADDR     <= '0;
      burst_cnt  <= '0;
      burst_addr <= '0;
    end else begin
      case (state)
        HALT: begin
          if (DISPON) begin
            state <= WAITVS;
          end
        end
        WAITVS: begin
          if (!DISPON) begin
            state <= HALT;
          end else if (frame_start) begin
            burst_addr <= {DISPADDR, 3'b000};
            burst_cnt  <= '0;
            FRAME_BUSY <= 1'b1;
            state      <= WAITBUF;
          end
        end
        WAITBUF: begin
          if (!DISPON) begin
            FRAME_BUSY <= 1'b0;
            state      <= HALT;
          end else if (FIFO_READY) begin
            ARADDR <= burst_addr;
            state  <= AREQ;
          end
        end
        AREQ: begin
          if (ARVALID && ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RDAT;
          end else begin
            ARVALID <= 1'b1;
          end
        end
        RDAT: begin
          if (burst_end) begin
            RREADY     <= 1'b0;
            burst_cnt  <= burst_cnt + CNT_W'(1);
            burst_addr <= burst_addr + 32'(BURST_BYTES);
            if (burst_cnt == LAST_BURST) begin
              FRAME_BUSY <= 1'b0;
              state      <= DISPON ? WAITVS : HALT;
            end else if (!DISPON) begin
              FRAME_BUSY <= 1'b0;
              state      <= HALT;
            end else begin
              state <= WAITBUF;
            end
          end
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_vramctrl.sv
// Directed bench for disp_vramctrl: frame tables plus hand-written corner sequences.
module tb_disp_vramctrl;

  localparam int unsigned FB = 4;
  localparam int unsigned BL = 16;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b1;
  logic        DISPON = 1'b0;
  logic [28:0] DISPADDR = '0;
  logic        DSP_VSYNC_X = 1'b1;
  logic        FIFO_READY = 1'b1;
  logic        ARREADY = 1'b0;
  logic [63:0] RDATA = '0;
  logic        RVALID = 1'b0;
  logic        RLAST = 1'b0;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID;
  logic        RREADY;
  logic        FIFO_WR;
  logic [63:0] FIFO_WDATA;
  logic        FRAME_BUSY;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  typedef struct {
    logic [28:0]       dispaddr;
    logic [3:0][31:0]  exp_addr;
    int                ar_delay;
    int                gap;
  } frame_vec_t;

  frame_vec_t vecs [3];

  always #5 ACLK = ~ACLK;

  disp_vramctrl #(.FRAME_BURSTS(FB), .BURST_LEN(BL)) dut (
    .ACLK(ACLK), .ARST(ARST), .DISPON(DISPON), .DISPADDR(DISPADDR),
    .DSP_VSYNC_X(DSP_VSYNC_X), .FIFO_READY(FIFO_READY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY),
    .FIFO_WR(FIFO_WR), .FIFO_WDATA(FIFO_WDATA), .FRAME_BUSY(FRAME_BUSY)
  );

  // Count FIFO writes mid-cycle and verify each carries the beat being driven.
  always @(negedge ACLK) begin
    if (FIFO_WR === 1'b1) begin
      wr_cnt++;
      checks++;
      if (FIFO_WDATA !== RDATA || RVALID !== 1'b1) begin
        errors++;
        $display("FAIL fifo_write: got data %0h rvalid %0b expected data %0h rvalid 1",
                 FIFO_WDATA, RVALID, RDATA);
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_frame();
    DSP_VSYNC_X = 1'b0;
    repeat (3) tick();
    DSP_VSYNC_X = 1'b1;
  endtask

  task automatic ar_hs(input logic [31:0] exp, input int delay);
    int   n = 0;
    logic moved = 1'b0;
    while (ARVALID !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("arvalid_seen", 64'(ARVALID), 64'(1));
    chk("araddr", 64'(ARADDR), 64'(exp));
    chk("arlen", 64'(ARLEN), 64'(BL - 1));
    for (int d = 0; d < delay; d++) begin
      tick();
      if (ARVALID !== 1'b1 || ARADDR !== exp) moved = 1'b1;
    end
    if (delay > 0) chk("araddr_stable", 64'(moved), 64'(0));
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    chk("arvalid_drop", 64'(ARVALID), 64'(0));
  endtask

  task automatic beats(input int gap, input int drop_at);
    int start = wr_cnt;
    for (int b = 0; b < int'(BL); b++) begin
      if (gap > 0 && (b % 2) == 1) begin
        RVALID = 1'b0;
        RLAST  = 1'b0;
        repeat (gap) tick();
      end
      if (b == drop_at) DISPON = 1'b0;
      RVALID = 1'b1;
      RDATA  = 64'hC0DE_0000_0000_0000 | 64'(b);
      RLAST  = (b == int'(BL) - 1);
      tick();
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    chk("beats_per_burst", 64'(wr_cnt - start), 64'(BL));
  endtask

  task automatic run_frame(input frame_vec_t v);
    int start = wr_cnt;
    for (int k = 0; k < int'(FB); k++) begin
      ar_hs(v.exp_addr[k], v.ar_delay);
      beats(v.gap, -1);
      if (k == 0) chk("busy_mid_frame", 64'(FRAME_BUSY), 64'(1));
    end
    chk("frame_beats", 64'(wr_cnt - start), 64'(FB * BL));
    chk("busy_after_frame", 64'(FRAME_BUSY), 64'(0));
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL timeout: got no end of test expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int hits;
    int n;
    int s;

    vecs[0].dispaddr = 29'h0200_0000;
    vecs[0].exp_addr = {32'h1000_0180, 32'h1000_0100, 32'h1000_0080, 32'h1000_0000};
    vecs[0].ar_delay = 0;
    vecs[0].gap      = 0;
    vecs[1].dispaddr = 29'h0000_0010;
    vecs[1].exp_addr = {32'h0000_0200, 32'h0000_0180, 32'h0000_0100, 32'h0000_0080};
    vecs[1].ar_delay = 10;
    vecs[1].gap      = 1;
    vecs[2].dispaddr = 29'h1FFF_FFF0;
    vecs[2].exp_addr = {32'h0000_0100, 32'h0000_0080, 32'h0000_0000, 32'hFFFF_FF80};
    vecs[2].ar_delay = 2;
    vecs[2].gap      = 0;

    // Reset values, with stray read data present.
    RVALID = 1'b1;
    repeat (3) tick();
    chk("rst_arvalid", 64'(ARVALID), 64'(0));
    chk("rst_rready", 64'(RREADY), 64'(0));
    chk("rst_fifo_wr", 64'(FIFO_WR), 64'(0));
    chk("rst_busy", 64'(FRAME_BUSY), 64'(0));
    chk("rst_araddr", 64'(ARADDR), 64'(0));
    chk("rst_arlen", 64'(ARLEN), 64'(BL - 1));
    RVALID = 1'b0;
    ARST   = 1'b0;
    DISPON = 1'b1;
    repeat (3) tick();

    // Table frames; the first also measures vsync-to-ARVALID latency.
    for (int i = 0; i < 3; i++) begin
      DISPADDR = vecs[i].dispaddr;
      if (i == 0) begin
        DSP_VSYNC_X = 1'b0;
        repeat (4) tick();
        chk("latency_edge3", 64'(ARVALID), 64'(0));
        tick();
        chk("latency_edge4", 64'(ARVALID), 64'(1));
        DSP_VSYNC_X = 1'b1;
      end else begin
        start_frame();
      end
      run_frame(vecs[i]);
    end

    // FIFO throttle after burst 1, with stray RVALID outside RDAT.
    DISPADDR = 29'h0;
    start_frame();
    ar_hs(32'h0000_0000, 0);
    beats(0, -1);
    FIFO_READY = 1'b0;
    hits = 0;
    s = wr_cnt;
    for (int c = 0; c < 50; c++) begin
      RVALID = (c < 10);
      RLAST  = (c < 10);
      tick();
      if (ARVALID === 1'b1) hits++;
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    chk("throttle_no_arvalid", 64'(hits), 64'(0));
    chk("stray_rvalid_no_wr", 64'(wr_cnt - s), 64'(0));
    FIFO_READY = 1'b1;
    n = 0;
    while (ARVALID !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("throttle_resume", 64'(n <= 2), 64'(1));
    for (int k = 1; k < int'(FB); k++) begin
      ar_hs(32'(k * 128), 0);
      beats(0, -1);
    end
    chk("throttle_busy_end", 64'(FRAME_BUSY), 64'(0));

    // Extra vsync and base change mid-frame: no restart, new base next frame.
    DISPADDR = 29'h0100_0000;
    start_frame();
    ar_hs(32'h0800_0000, 0);
    beats(0, -1);
    DISPADDR = 29'h0300_0000;
    start_frame();
    chk("extra_vsync_busy", 64'(FRAME_BUSY), 64'(1));
    for (int k = 1; k < int'(FB); k++) begin
      ar_hs(32'h0800_0000 + 32'(k * 128), 0);
      beats(0, -1);
    end
    chk("old_frame_end", 64'(FRAME_BUSY), 64'(0));
    start_frame();
    for (int k = 0; k < int'(FB); k++) begin
      ar_hs(32'h1800_0000 + 32'(k * 128), 0);
      beats(0, -1);
    end
    chk("new_base_frame_end", 64'(FRAME_BUSY), 64'(0));

    // DISPON drop at beat 5: burst completes, then halt.
    DISPADDR = 29'h0200_0000;
    start_frame();
    ar_hs(32'h1000_0000, 0);
    beats(0, 5);
    chk("drop_busy", 64'(FRAME_BUSY), 64'(0));
    chk("drop_rready", 64'(RREADY), 64'(0));
    hits = 0;
    start_frame();
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ARVALID === 1'b1) hits++;
    end
    chk("halt_no_arvalid", 64'(hits), 64'(0));
    DISPON = 1'b1;
    repeat (3) tick();

    // Reset in the middle of a burst.
    start_frame();
    ar_hs(32'h1000_0000, 0);
    RVALID = 1'b1;
    RLAST  = 1'b0;
    repeat (3) tick();
    ARST = 1'b1;
    #1;
    chk("midrst_arvalid", 64'(ARVALID), 64'(0));
    chk("midrst_rready", 64'(RREADY), 64'(0));
    chk("midrst_fifo_wr", 64'(FIFO_WR), 64'(0));
    chk("midrst_busy", 64'(FRAME_BUSY), 64'(0));
    chk("midrst_araddr", 64'(ARADDR), 64'(0));
    chk("midrst_arlen", 64'(ARLEN), 64'(BL - 1));
    RVALID = 1'b0;
    repeat (2) tick();
    ARST = 1'b0;
    repeat (3) tick();
    start_frame();
    run_frame(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
